// File: rtl/phy_init_seq.sv
// PHY bring-up sequencer on the MDIO driver clock: pulses the PHY hardware
// reset, checks the PHY identifier, writes and verifies a register table,
// then polls register 1 for link status until re-initialised.
module phy_init_seq #(
  parameter logic [21:0] RST_CYCLES      = 22'd200_000,
  parameter logic [21:0] RST_WAIT_CYCLES = 22'd100_000,
  parameter logic [15:0] PHY_ID1         = 16'h0141,
  parameter int unsigned N_INIT          = 3,
  parameter logic [83:0] INIT_TABLE      = 84'h0,
  parameter logic [15:0] VERIFY_MASK     = 16'h7FFF,
  parameter logic [23:0] POLL_PERIOD     = 24'd100_000,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_init,
  input  logic        op_done,
  input  logic [15:0] op_rd_data,
  input  logic        op_rd_ack,
  output logic        eth_rst_n,
  output logic        op_exec,
  output logic        op_rh_wl,
  output logic [4:0]  op_addr,
  output logic [15:0] op_wr_data,
  output logic        init_done,
  output logic        init_err,
  output logic [1:0]  err_code,
  output logic        link_up
);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_RST_WAIT,
    S_ID_RD,
    S_WR,
    S_VFY,
    S_POLL_WAIT,
    S_POLL_RD,
    S_ERR
  } state_e;

  localparam logic [1:0]  ERR_ID   = 2'd0;
  localparam logic [1:0]  ERR_VFY  = 2'd1;
  localparam logic [1:0]  ERR_NACK = 2'd2;
  localparam logic [1:0]  ERR_TMO  = 2'd3;

  localparam logic [4:0]  REG_STATUS = 5'd1;
  localparam logic [4:0]  REG_PHYID1 = 5'd2;

  localparam logic [1:0]  LAST_IDX  = 2'(N_INIT - 1);
  localparam logic [23:0] HOLD_LAST = 24'(RST_CYCLES) - 24'd1;
  // One extra settle cycle so the first op_exec lands RST_WAIT_CYCLES+1
  // cycles after eth_rst_n rises.
  localparam logic [23:0] WAIT_LAST = 24'(RST_WAIT_CYCLES);
  localparam logic [23:0] POLL_LAST = POLL_PERIOD - 24'd1;
  localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        wait_q, wait_d;       // 0 = ISSUE cycle, 1 = waiting for op_done
  logic [1:0]  idx_q, idx_d;         // table entry index for WR / VFY
  logic [23:0] cnt_q, cnt_d;         // shared hold / settle / poll / timeout counter
  logic        init_done_q, init_done_d;
  logic        init_err_q, init_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        link_up_q, link_up_d;

  logic        err_hit;
  logic [1:0]  err_val;
  logic [4:0]  ent_addr;
  logic [15:0] ent_data;

  assign ent_addr = INIT_TABLE[21*int'(idx_q) + 16 +: 5];
  assign ent_data = INIT_TABLE[21*int'(idx_q) +: 16];

  // State and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RST_HOLD;
      wait_q      <= 1'b0;
      idx_q       <= 2'd0;
      cnt_q       <= 24'd0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      err_code_q  <= ERR_ID;
      link_up_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, independent of statement order.
      state_q     <= state_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      err_code_q  <= err_code_d;
      link_up_q   <= link_up_d;
    end
  end

  // Next-state, counter and flag logic; re_init overrides everything.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    err_code_d  = err_code_q;
    link_up_d   = link_up_q;
    err_hit     = 1'b0;
    err_val     = ERR_ID;

    if (re_init) begin
      state_d     = S_RST_HOLD;
      wait_d      = 1'b0;
      idx_d       = 2'd0;
      cnt_d       = 24'd0;
      init_done_d = 1'b0;
      init_err_d  = 1'b0;
      err_code_d  = ERR_ID;
      link_up_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_RST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_RST_WAIT;
            cnt_d   = 24'd0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        S_RST_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_d = S_ID_RD;
            wait_d  = 1'b0;
            cnt_d   = 24'd0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        S_POLL_WAIT: begin
          if (cnt_q == POLL_LAST) begin
            state_d = S_POLL_RD;
            wait_d  = 1'b0;
            cnt_d   = 24'd0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        S_ID_RD, S_WR, S_VFY, S_POLL_RD: begin
          if (!wait_q) begin
            wait_d = 1'b1;
            cnt_d  = 24'd0;
          end else if (op_done) begin
            wait_d = 1'b0;
            cnt_d  = 24'd0;
            if (state_q != S_WR && op_rd_ack) begin
              err_hit = 1'b1;
              err_val = ERR_NACK;
            end else begin
              case (state_q)
                S_ID_RD: begin
                  if (op_rd_data != PHY_ID1) begin
                    err_hit = 1'b1;
                    err_val = ERR_ID;
                  end else begin
                    state_d = S_WR;
                    idx_d   = 2'd0;
                  end
                end
                S_WR: begin
                  if (idx_q == LAST_IDX) begin
                    state_d = S_VFY;
                    idx_d   = 2'd0;
                  end else begin
                    idx_d = idx_q + 2'd1;
                  end
                end
                S_VFY: begin
                  if (((op_rd_data ^ ent_data) & VERIFY_MASK) != 16'h0000) begin
                    err_hit = 1'b1;
                    err_val = ERR_VFY;
                  end else if (idx_q == LAST_IDX) begin
                    state_d     = S_POLL_WAIT;
                    idx_d       = 2'd0;
                    init_done_d = 1'b1;
                  end else begin
                    idx_d = idx_q + 2'd1;
                  end
                end
                S_POLL_RD: begin
                  link_up_d = op_rd_data[2];
                  state_d   = S_POLL_WAIT;
                end
                default: ;
              endcase
            end
          end else if (cnt_q == TMO_LAST) begin
            err_hit = 1'b1;
            err_val = ERR_TMO;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        S_ERR: ;
        default: state_d = S_RST_HOLD;
      endcase

      if (err_hit) begin
        state_d     = S_ERR;
        wait_d      = 1'b0;
        cnt_d       = 24'd0;
        init_done_d = 1'b0;
        init_err_d  = 1'b1;
        err_code_d  = err_val;
      end
    end
  end

  // MDIO operation port and PHY reset decoded from the current state; the
  // fields stay constant for the whole ISSUE/WAIT span of an operation.
  always_comb begin
    eth_rst_n  = (state_q != S_RST_HOLD);
    op_exec    = 1'b0;
    op_rh_wl   = 1'b0;
    op_addr    = 5'd0;
    op_wr_data = 16'h0000;
    case (state_q)
      S_ID_RD: begin
        op_exec  = !wait_q;
        op_rh_wl = 1'b1;
        op_addr  = REG_PHYID1;
      end
      S_WR: begin
        op_exec    = !wait_q;
        op_addr    = ent_addr;
        op_wr_data = ent_data;
      end
      S_VFY: begin
        op_exec  = !wait_q;
        op_rh_wl = 1'b1;
        op_addr  = ent_addr;
      end
      S_POLL_RD: begin
        op_exec  = !wait_q;
        op_rh_wl = 1'b1;
        op_addr  = REG_STATUS;
      end
      default: ;
    endcase
  end

  assign init_done = init_done_q;
  assign init_err  = init_err_q;
  assign err_code  = err_code_q;
  assign link_up   = link_up_q;

endmodule

// File: tb/tb_phy_init_seq.sv
// Directed bench for phy_init_seq with a small MDIO driver model that logs
// every operation and answers after a fixed latency.
module tb_phy_init_seq;

  localparam logic [83:0] TABLE = {42'h0, 5'h09, 16'h0200, 5'h00, 16'h1140};
  localparam int LAT = 3;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re_init = 1'b0;
  logic        op_done = 1'b0;
  logic [15:0] op_rd_data = 16'h0000;
  logic        op_rd_ack = 1'b0;
  logic        eth_rst_n, op_exec, op_rh_wl;
  logic [4:0]  op_addr;
  logic [15:0] op_wr_data;
  logic        init_done, init_err, link_up;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  phy_init_seq #(
    .RST_CYCLES     (22'd10),
    .RST_WAIT_CYCLES(22'd5),
    .PHY_ID1        (16'h0141),
    .N_INIT         (2),
    .INIT_TABLE     (TABLE),
    .VERIFY_MASK    (16'h7FFF),
    .POLL_PERIOD    (24'd20),
    .TIMEOUT_CYCLES (16'(TMO))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .re_init   (re_init),
    .op_done   (op_done),
    .op_rd_data(op_rd_data),
    .op_rd_ack (op_rd_ack),
    .eth_rst_n (eth_rst_n),
    .op_exec   (op_exec),
    .op_rh_wl  (op_rh_wl),
    .op_addr   (op_addr),
    .op_wr_data(op_wr_data),
    .init_done (init_done),
    .init_err  (init_err),
    .err_code  (err_code),
    .link_up   (link_up)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- MDIO driver model ----------------
  logic [15:0] id_val   = 16'h0141;
  logic [15:0] poll_val = 16'h796D;
  logic [15:0] ovr_val  = 16'h0000;
  bit          ovr_en   = 1'b0;
  bit          hang     = 1'b0;
  int          nack_addr = -1;
  logic [15:0] mem [32];
  logic [21:0] ops [$];
  int          pend = -1;
  int          done_cyc = 0;
  int          exec_cyc = 0;
  int          b2b = 0;
  logic        prev_exec = 1'b0;
  logic        cur_rh = 1'b0;
  logic [4:0]  cur_addr = 5'd0;
  logic [15:0] cur_wd = 16'h0000;

  function automatic logic [15:0] model_read(input logic [4:0] a);
    if (a == 5'd2) return id_val;
    if (a == 5'd1) return poll_val;
    if (a == 5'd0 && ovr_en) return ovr_val;
    return mem[a];
  endfunction

  always begin
    @(negedge clk);
    op_done    = 1'b0;
    op_rd_ack  = 1'b0;
    op_rd_data = 16'h0000;
    if (pend == 0) begin
      op_done  = 1'b1;
      done_cyc = cyc;
      if (cur_rh) begin
        op_rd_data = model_read(cur_addr);
        op_rd_ack  = (int'(cur_addr) == nack_addr);
      end else begin
        mem[cur_addr] = cur_wd;
      end
      pend = -1;
    end else if (pend > 0) begin
      pend = pend - 1;
    end
    if (op_exec === 1'b1) begin
      if (prev_exec === 1'b1) b2b = b2b + 1;
      ops.push_back({op_rh_wl, op_addr, op_wr_data});
      exec_cyc = cyc;
      cur_rh   = op_rh_wl;
      cur_addr = op_addr;
      cur_wd   = op_wr_data;
      if (!hang) pend = LAT;
    end
    prev_exec = op_exec;
  end

  // ---------------- helpers (stimulus only) ----------------
  function automatic logic [21:0] exp_op(input int i);
    case (i)
      0:       return {1'b1, 5'h02, 16'h0000};
      1:       return {1'b0, 5'h00, 16'h1140};
      2:       return {1'b0, 5'h09, 16'h0200};
      3:       return {1'b1, 5'h00, 16'h0000};
      default: return {1'b1, 5'h09, 16'h0000};
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_re_init();
    re_init = 1'b1;
    tick();
    re_init = 1'b0;
  endtask

  task automatic measure_bringup(output int low_n, output int wait_n);
    low_n = 0;
    while (eth_rst_n !== 1'b1 && low_n < 1000) begin low_n++; tick(); end
    wait_n = 0;
    while (op_exec !== 1'b1 && wait_n < 1000) begin wait_n++; tick(); end
  endtask

  task automatic wait_end(input int max_cyc, output bit to);
    int n = 0;
    to = 1'b0;
    while (init_done !== 1'b1 && init_err !== 1'b1) begin
      if (n == max_cyc) begin to = 1'b1; return; end
      n++;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({eth_rst_n, op_exec, op_rh_wl, op_addr, op_wr_data, init_done, init_err, err_code, link_up} !== 30'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {eth_rst_n, op_exec, op_rh_wl, op_addr, op_wr_data, init_done, init_err, err_code, link_up});
    end
  endtask

  task automatic test_bringup();
    int low_n, wait_n, base;
    bit to;
    base = ops.size();
    rst = 1'b0;
    measure_bringup(low_n, wait_n);
    checks++; if (low_n !== 10) begin failures++; $display("FAIL bringup_rst_low got=%0d exp=10", low_n); end
    checks++; if (wait_n !== 6) begin failures++; $display("FAIL bringup_first_exec got=%0d exp=6", wait_n); end
    wait_end(300, to);
    checks++; if (to) begin failures++; $display("FAIL bringup_wait got=timeout exp=done"); end
    checks++; if (init_done !== 1'b1 || init_err !== 1'b0) begin
      failures++; $display("FAIL bringup_flags got=%b%b exp=10", init_done, init_err);
    end
    checks++; if (cyc - done_cyc !== 1) begin failures++; $display("FAIL bringup_done_latency got=%0d exp=1", cyc - done_cyc); end
    checks++; if (ops.size() - base !== 5) begin failures++; $display("FAIL bringup_op_count got=%0d exp=5", ops.size() - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ops[base + i] !== exp_op(i)) begin
        failures++; $display("FAIL bringup_op%0d got=%h exp=%h", i, ops[base + i], exp_op(i));
      end
    end
    checks++; if (b2b !== 0) begin failures++; $display("FAIL back_to_back_exec got=%0d exp=0", b2b); end
  endtask

  task automatic test_link_poll();
    int n, d1, nops;
    n = 0;
    while (link_up !== 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (link_up !== 1'b1) begin failures++; $display("FAIL poll_link_up got=%b exp=1", link_up); end
    checks++; if (cyc - done_cyc !== 1) begin failures++; $display("FAIL poll_link_latency got=%0d exp=1", cyc - done_cyc); end
    checks++; if (ops[ops.size() - 1] !== {1'b1, 5'h01, 16'h0000}) begin
      failures++; $display("FAIL poll_op got=%h exp=%h", ops[ops.size() - 1], {1'b1, 5'h01, 16'h0000});
    end
    poll_val = 16'h7969;
    d1 = done_cyc;
    nops = ops.size();
    n = 0;
    while (ops.size() == nops && n < 100) begin n++; tick(); end
    checks++; if (exec_cyc - d1 !== 21) begin failures++; $display("FAIL poll_spacing got=%0d exp=21", exec_cyc - d1); end
    n = 0;
    while (link_up !== 1'b0 && n < 100) begin n++; tick(); end
    checks++; if (link_up !== 1'b0 || init_done !== 1'b1) begin
      failures++; $display("FAIL poll_link_down got=%b%b exp=01", link_up, init_done);
    end
  endtask

  task automatic test_poll_nack();
    int n;
    poll_val = 16'h796D;
    n = 0;
    while (link_up !== 1'b1 && n < 100) begin n++; tick(); end
    nack_addr = 1;
    n = 0;
    while (init_err !== 1'b1 && n < 100) begin n++; tick(); end
    checks++;
    if ({init_err, err_code, init_done, link_up, eth_rst_n} !== 6'b1_10_0_1_1) begin
      failures++; $display("FAIL poll_nack got=%b exp=110011", {init_err, err_code, init_done, link_up, eth_rst_n});
    end
    nack_addr = -1;
  endtask

  task automatic test_id_mismatch();
    int low_n, wait_n, base;
    bit to;
    id_val = 16'h0000;
    do_re_init();
    checks++;
    if ({init_done, init_err, err_code, link_up, eth_rst_n} !== 6'b0) begin
      failures++; $display("FAIL re_init_in_err_clear got=%b exp=000000", {init_done, init_err, err_code, link_up, eth_rst_n});
    end
    base = ops.size();
    measure_bringup(low_n, wait_n);
    wait_end(300, to);
    checks++; if (init_err !== 1'b1 || err_code !== 2'd0) begin
      failures++; $display("FAIL id_mismatch got=%b/%0d exp=1/0", init_err, err_code);
    end
    repeat (30) tick();
    checks++; if (ops.size() - base !== 1 || eth_rst_n !== 1'b1 || init_done !== 1'b0) begin
      failures++; $display("FAIL id_no_write got=%0d ops rst_n=%b exp=1 ops rst_n=1", ops.size() - base, eth_rst_n);
    end
    id_val = 16'h0141;
  endtask

  task automatic test_verify_mask();
    int low_n, wait_n, base;
    bit to;
    ovr_en = 1'b1;
    ovr_val = 16'h9140;
    do_re_init();
    measure_bringup(low_n, wait_n);
    wait_end(300, to);
    checks++; if (init_done !== 1'b1 || init_err !== 1'b0) begin
      failures++; $display("FAIL verify_masked_bit15 got=%b%b exp=10", init_done, init_err);
    end
    ovr_val = 16'h1100;
    do_re_init();
    base = ops.size();
    measure_bringup(low_n, wait_n);
    wait_end(300, to);
    checks++; if (init_err !== 1'b1 || err_code !== 2'd1 || ops.size() - base !== 4) begin
      failures++; $display("FAIL verify_mismatch got=%b/%0d/%0d exp=1/1/4", init_err, err_code, ops.size() - base);
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_nack();
    int low_n, wait_n, base;
    bit to;
    nack_addr = 9;
    do_re_init();
    base = ops.size();
    measure_bringup(low_n, wait_n);
    wait_end(300, to);
    checks++; if (init_err !== 1'b1 || err_code !== 2'd2 || init_done !== 1'b0 || ops.size() - base !== 5) begin
      failures++; $display("FAIL read_nack got=%b/%0d/%0d exp=1/2/5", init_err, err_code, ops.size() - base);
    end
    nack_addr = -1;
  endtask

  task automatic test_timeout();
    int low_n, wait_n, base;
    bit to;
    hang = 1'b1;
    do_re_init();
    base = ops.size();
    measure_bringup(low_n, wait_n);
    wait_end(300, to);
    checks++; if (init_err !== 1'b1 || err_code !== 2'd3) begin
      failures++; $display("FAIL timeout_code got=%b/%0d exp=1/3", init_err, err_code);
    end
    // Counter reaches TMO in cycle exec+1+TMO; the flag shows one cycle later.
    checks++; if (cyc - exec_cyc !== TMO + 2) begin
      failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", cyc - exec_cyc, TMO + 2);
    end
    repeat (20) tick();
    checks++; if (ops.size() - base !== 1) begin failures++; $display("FAIL err_no_exec got=%0d exp=1", ops.size() - base); end
  endtask

  task automatic test_re_init_in_err();
    int low_n, wait_n, base;
    bit to;
    hang = 1'b0;
    do_re_init();
    checks++; if ({init_err, err_code, eth_rst_n} !== 4'b0) begin
      failures++; $display("FAIL err_re_init_clear got=%b exp=0000", {init_err, err_code, eth_rst_n});
    end
    base = ops.size();
    measure_bringup(low_n, wait_n);
    checks++; if (low_n !== 10 || wait_n !== 6) begin
      failures++; $display("FAIL err_re_init_timing got=%0d/%0d exp=10/6", low_n, wait_n);
    end
    wait_end(300, to);
    checks++; if (init_done !== 1'b1 || ops.size() - base !== 5) begin
      failures++; $display("FAIL err_re_init_pass got=%b/%0d exp=1/5", init_done, ops.size() - base);
    end
  endtask

  task automatic test_re_init_mid_write();
    int low_n, wait_n, base, n;
    bit to;
    do_re_init();
    checks++; if (init_done !== 1'b0 || eth_rst_n !== 1'b0) begin
      failures++; $display("FAIL poll_re_init_clear got=%b%b exp=00", init_done, eth_rst_n);
    end
    n = 0;
    while (!(op_exec === 1'b1 && op_rh_wl === 1'b0) && n < 200) begin n++; tick(); end
    checks++; if (op_exec !== 1'b1) begin failures++; $display("FAIL mid_write_reach got=%b exp=1", op_exec); end
    tick();
    do_re_init();
    checks++; if (eth_rst_n !== 1'b0 || init_done !== 1'b0) begin
      failures++; $display("FAIL mid_write_rst got=%b%b exp=00", eth_rst_n, init_done);
    end
    base = ops.size();
    measure_bringup(low_n, wait_n);
    checks++; if (low_n !== 10 || wait_n !== 6) begin
      failures++; $display("FAIL mid_write_stale_done got=%0d/%0d exp=10/6", low_n, wait_n);
    end
    wait_end(300, to);
    checks++; if (init_done !== 1'b1 || init_err !== 1'b0 || ops.size() - base !== 5) begin
      failures++; $display("FAIL mid_write_repeat got=%b%b/%0d exp=10/5", init_done, init_err, ops.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ops[base + i] !== exp_op(i)) begin
        failures++; $display("FAIL mid_write_op%0d got=%h exp=%h", i, ops[base + i], exp_op(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_link_poll();
    test_poll_nack();
    test_id_mismatch();
    test_verify_mask();
    test_nack();
    test_timeout();
    test_re_init_in_err();
    test_re_init_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
